// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and defaults for the programmable serial-pattern
// detection controller.
//   state_t     : controller state encoding {IDLE, RUN, DONE}
//   DEF_PATTERN : pattern loaded at reset (LSB-aligned, 1011)
//   DEF_LEN     : pattern length loaded at reset
//   len_w()     : width of a length field able to hold 0..pat_w
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
  localparam int         DEF_LEN     = 4;

  // Length field must encode every value from 0 up to and including pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// seq_det_core: bit history, fill counter and masked comparator.
//   clk, reset   : clock and synchronous active-high reset
//   shift_en     : accept bit_in this cycle
//   bit_in       : serial data bit
//   clear        : empty history and fill (frame start)
//   cfg_pattern  : pattern, LSB-aligned, bit [cfg_len-1] received first
//   cfg_len      : pattern length (1..PAT_W)
//   cfg_overlap  : 1 keeps fill after a hit, 0 restarts the window
//   hit          : combinational; high when the bit being shifted in now
//                  completes the pattern
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clear,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             hit
);

  logic [PAT_W-1:0] history_r;
  logic [LEN_W-1:0] fill_r;
  logic [PAT_W-1:0] hist_next_s;
  logic [LEN_W-1:0] fill_inc_s;
  logic [PAT_W-1:0] mask_s;
  logic             hit_s;

  // Look-ahead: evaluate the window as it will be after this bit, so the
  // registered match pulse lands in the cycle right after acceptance.
  always_comb begin
    hist_next_s = {history_r[PAT_W-2:0], bit_in};
    if (fill_r == LEN_W'(PAT_W)) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + {{(LEN_W-1){1'b0}}, 1'b1};
    end
    mask_s = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (LEN_W'(i) < cfg_len);
    end
    hit_s = shift_en && (fill_inc_s >= cfg_len) &&
            (((hist_next_s ^ cfg_pattern) & mask_s) == {PAT_W{1'b0}});
  end

  assign hit = hit_s;

  // History and fill registers; a non-overlapping hit empties the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      history_r <= {PAT_W{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
    end else if (clear) begin
      history_r <= {PAT_W{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
    end else if (shift_en) begin
      history_r <= hist_next_s;
      if (hit_s && !cfg_overlap) begin
        fill_r <= {LEN_W{1'b0}};
      end else begin
        fill_r <= fill_inc_s;
      end
    end else begin
      history_r <= history_r;
      fill_r    <= fill_r;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial-pattern detection controller.
//   clk, reset        : clock and synchronous active-high reset
//   cfg_we            : config write strobe (IDLE only)
//   cfg_pattern/len/overlap : configuration fields
//   cfg_err           : one-cycle pulse after a rejected write
//   start / busy      : frame start (IDLE only) / high in RUN and DONE
//   bit_valid/bit_in/bit_last/bit_ready : serial bit handshake
//   match             : one-cycle pulse per detected match
//   match_count       : saturating count for the current / last frame
//   done / done_ack   : frame-result handshake
module seq_det_ctrl
  import seq_det_pkg::state_t, seq_det_pkg::IDLE, seq_det_pkg::RUN,
         seq_det_pkg::DONE, seq_det_pkg::len_w;
#(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(seq_det_pkg::DEF_PATTERN),
  parameter int               DEF_LEN     = seq_det_pkg::DEF_LEN,
  parameter int               LEN_W       = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             cfg_err,
  input  logic             start,
  output logic             busy,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             bit_last,
  output logic             bit_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  input  logic             done_ack
);

  state_t           state_r;
  state_t           state_next_s;

  logic [PAT_W-1:0] cfg_pattern_r;
  logic [LEN_W-1:0] cfg_len_r;
  logic             cfg_overlap_r;

  logic             cfg_err_r;
  logic             busy_r;
  logic             ready_r;
  logic             done_r;
  logic             match_r;
  logic [CNT_W-1:0] count_r;

  logic             in_idle_s;
  logic             accept_s;
  logic             start_go_s;
  logic             cfg_legal_s;
  logic             cfg_load_s;
  logic             hit_s;

  // Handshake qualifiers; config and start are only honoured while idle.
  always_comb begin
    in_idle_s   = (state_r == IDLE);
    accept_s    = bit_valid && (state_r == RUN);
    start_go_s  = in_idle_s && start;
    cfg_legal_s = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(PAT_W));
    cfg_load_s  = in_idle_s && cfg_we && cfg_legal_s;
  end

  seq_det_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .shift_en    (accept_s),
    .bit_in      (bit_in),
    .clear       (start_go_s),
    .cfg_pattern (cfg_pattern_r),
    .cfg_len     (cfg_len_r),
    .cfg_overlap (cfg_overlap_r),
    .hit         (hit_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && bit_last) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (done_ack) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Configuration registers; a write in the start cycle is seen by that
  // frame because the core reads these registers only from RUN onward.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_pattern_r <= DEF_PATTERN;
      cfg_len_r     <= LEN_W'(DEF_LEN);
      cfg_overlap_r <= 1'b1;
      cfg_err_r     <= 1'b0;
    end else begin
      cfg_err_r <= in_idle_s && cfg_we && !cfg_legal_s;
      if (cfg_load_s) begin
        cfg_pattern_r <= cfg_pattern;
        cfg_len_r     <= cfg_len;
        cfg_overlap_r <= cfg_overlap;
      end else begin
        cfg_pattern_r <= cfg_pattern_r;
        cfg_len_r     <= cfg_len_r;
        cfg_overlap_r <= cfg_overlap_r;
      end
    end
  end

  // Registered status outputs, decoded from the next state so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      match_r <= 1'b0;
    end else begin
      busy_r  <= (state_next_s != IDLE);
      ready_r <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
      match_r <= accept_s && hit_s;
    end
  end

  // Saturating match counter, cleared only by a new frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (start_go_s) begin
      count_r <= {CNT_W{1'b0}};
    end else if (accept_s && hit_s && !(&count_r)) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign cfg_err     = cfg_err_r;
  assign busy        = busy_r;
  assign bit_ready   = ready_r;
  assign done        = done_r;
  assign match       = match_r;
  assign match_count = count_r;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed plus randomized bench for seq_det_ctrl. A second
// instance with a 2-bit counter shares all inputs to observe saturation.
module tb_seq_det_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset, cfg_we, cfg_overlap, start;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             bit_valid, bit_in, bit_last, done_ack;

  logic             cfg_err, busy, bit_ready, match, done;
  logic [7:0]       match_count;
  logic             s_cfg_err, s_busy, s_bit_ready, s_match, s_done;
  logic [1:0]       s_match_count;

  int tests = 0;
  int fails = 0;

  // Reference configuration as the spec's rules say it should be.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ov;

  bit   tx_q[$];
  bit   hist_q[$];

  // Config applied together with start, when cs_en is set.
  bit         cs_en = 1'b0;
  logic [7:0] cs_pat;
  logic [3:0] cs_len;
  bit         cs_ov;

  always #5 clk = ~clk;

  seq_det_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
    .start(start), .busy(busy), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_last(bit_last), .bit_ready(bit_ready), .match(match),
    .match_count(match_count), .done(done), .done_ack(done_ack)
  );

  seq_det_ctrl #(.PAT_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(s_cfg_err),
    .start(start), .busy(s_busy), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_last(bit_last), .bit_ready(s_bit_ready), .match(s_match),
    .match_count(s_match_count), .done(s_done), .done_ack(done_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_defaults();
    m_pat = 8'h0B;
    m_len = 4;
    m_ov  = 1'b1;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_busy"},   busy, 0);
    chk({pfx, "_ready"},  bit_ready, 0);
    chk({pfx, "_match"},  match, 0);
    chk({pfx, "_done"},   done, 0);
    chk({pfx, "_count"},  match_count, 0);
    chk({pfx, "_err"},    cfg_err, 0);
    chk({pfx, "_scount"}, s_match_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; cfg_we = 1'b0; start = 1'b0; bit_valid = 1'b0;
    bit_in = 1'b0; bit_last = 1'b0; done_ack = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    model_defaults();
    tick();
  endtask

  task automatic cfg_write(input logic [7:0] p, input logic [3:0] l, input bit ov);
    bit legal;
    legal = (l != 4'd0) && (l <= 4'd8);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    tick();
    cfg_we = 1'b0;
    chk("cfg_err_pulse", cfg_err, !legal);
    if (legal) begin
      m_pat = p; m_len = int'(l); m_ov = ov;
    end
    tick();
    chk("cfg_err_clear", cfg_err, 0);
  endtask

  // True when the most recent m_len bits of hist_q spell the pattern,
  // oldest bit compared against pattern bit [m_len-1].
  function automatic bit tail_matches();
    for (int k = 0; k < m_len; k++) begin
      if (hist_q[hist_q.size()-1-k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic send_frame(input int gap_pct, input bit mid_cfg, output int final_cnt);
    int  cnt, since, gaps, n, satc;
    bit  hit, legal_cs;
    // Bits offered while idle must be refused.
    bit_valid = 1'b1; bit_in = 1'b1; bit_last = 1'b1;
    tick();
    chk("idle_ready", bit_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_match", match, 0);
    bit_valid = 1'b0; bit_last = 1'b0;
    start = 1'b1;
    legal_cs = 1'b0;
    if (cs_en) begin
      cfg_we = 1'b1; cfg_pattern = cs_pat; cfg_len = cs_len; cfg_overlap = cs_ov;
      legal_cs = (cs_len != 4'd0) && (cs_len <= 4'd8);
    end
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    if (cs_en) begin
      chk("start_cfg_err", cfg_err, !legal_cs);
      if (legal_cs) begin
        m_pat = cs_pat; m_len = int'(cs_len); m_ov = cs_ov;
      end
      cs_en = 1'b0;
    end
    chk("run_ready", bit_ready, 1);
    chk("run_busy", busy, 1);
    chk("run_count0", match_count, 0);
    chk("run_done0", done, 0);
    cnt = 0; since = 0; hist_q.delete();
    n = tx_q.size();
    for (int i = 0; i < n; i++) begin
      gaps = ($urandom_range(99) < gap_pct) ? $urandom_range(1, 3) : 0;
      repeat (gaps) begin
        bit_valid = 1'b0; bit_in = 1'($urandom); bit_last = 1'($urandom);
        tick();
        chk("gap_match", match, 0);
        chk("gap_count", match_count, cnt > 255 ? 255 : cnt);
        chk("gap_done", done, 0);
      end
      if (mid_cfg && i == 1) begin
        cfg_we = 1'b1; cfg_pattern = ~m_pat; cfg_len = 4'd2; cfg_overlap = ~m_ov;
      end
      bit_valid = 1'b1; bit_in = tx_q[i]; bit_last = (i == n - 1);
      tick();
      bit_valid = 1'b0; bit_last = 1'b0; cfg_we = 1'b0;
      hist_q.push_back(tx_q[i]);
      since++;
      hit = (since >= m_len) && tail_matches();
      if (hit) begin
        cnt++;
        if (!m_ov) since = 0;
      end
      satc = cnt > 3 ? 3 : cnt;
      chk("bit_match", match, hit);
      chk("bit_count", match_count, cnt > 255 ? 255 : cnt);
      chk("sat_count", s_match_count, satc);
      chk("bit_done", done, i == n - 1);
      chk("bit_ready", bit_ready, i != n - 1);
      if (mid_cfg && i == 1) chk("run_cfg_err", cfg_err, 0);
    end
    // Result held while the consumer stalls; offered bits are ignored.
    repeat (10) begin
      bit_valid = 1'($urandom); bit_in = 1'($urandom); bit_last = 1'($urandom);
      tick();
      chk("hold_done", done, 1);
      chk("hold_ready", bit_ready, 0);
      chk("hold_count", match_count, cnt > 255 ? 255 : cnt);
      chk("hold_match", match, 0);
    end
    bit_valid = 1'b0; bit_last = 1'b0;
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    chk("ack_done", done, 0);
    chk("ack_busy", busy, 0);
    chk("ack_count", match_count, cnt > 255 ? 255 : cnt);
    final_cnt = cnt;
  endtask

  initial begin
    int c, n;
    logic [7:0] rp;
    model_defaults();
    do_reset();

    // Default 1011 with overlap: matches after bits 4 and 7.
    tx_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    send_frame(0, 1'b0, c);
    chk("def_count", match_count, 2);
    send_frame(50, 1'b0, c);
    chk("def_gap_count", match_count, 2);

    // Non-overlapping 1011.
    cfg_write(8'h0B, 4'd4, 1'b0);
    send_frame(0, 1'b0, c);
    chk("novl_count", match_count, 1);
    send_frame(50, 1'b0, c);
    chk("novl_gap_count", match_count, 1);

    // Short pattern 11.
    tx_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    cfg_write(8'h03, 4'd2, 1'b1);
    send_frame(0, 1'b0, c);
    chk("short_ovl_count", match_count, 3);
    cfg_write(8'h03, 4'd2, 1'b0);
    send_frame(40, 1'b0, c);
    chk("short_novl_count", match_count, 2);

    // Rejected writes leave the 11/no-overlap config in place.
    cfg_write(8'hFF, 4'd0, 1'b1);
    cfg_write(8'hFF, 4'd9, 1'b1);
    send_frame(0, 1'b0, c);
    chk("err_keep_count", match_count, 2);

    // Write attempted mid-frame is ignored.
    send_frame(0, 1'b1, c);
    chk("run_cfg_count", match_count, 2);

    // Config applied in the start cycle is used by that frame; an illegal
    // one leaves the previous config in force.
    tx_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    cs_en = 1'b1; cs_pat = 8'h0B; cs_len = 4'd4; cs_ov = 1'b1;
    send_frame(0, 1'b0, c);
    chk("cs_legal_count", match_count, 2);
    cs_en = 1'b1; cs_pat = 8'h03; cs_len = 4'd0; cs_ov = 1'b0;
    send_frame(0, 1'b0, c);
    chk("cs_illegal_count", match_count, 2);

    // Saturation on the 2-bit counter instance.
    cfg_write(8'h03, 4'd2, 1'b1);
    tx_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    send_frame(30, 1'b0, c);
    chk("sat_main_count", match_count, 6);
    chk("sat_small_count", s_match_count, 3);

    // Reset in the middle of a custom-config frame.
    cfg_write(8'h06, 4'd4, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      bit_valid = 1'b1; bit_in = 1'($urandom); bit_last = 1'b0;
      tick();
    end
    bit_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_zero("midrst");
    reset = 1'b0;
    model_defaults();
    tick();
    tx_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    send_frame(0, 1'b0, c);
    chk("midrst_default_count", match_count, 2);

    // Randomized configs and frames biased toward the active pattern.
    for (int f = 0; f < 25; f++) begin
      rp = 8'($urandom);
      cfg_write(rp, 4'($urandom_range(0, 10)), 1'($urandom));
      tx_q.delete();
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(3) == 0) tx_q.push_back(1'($urandom));
        else tx_q.push_back(m_pat[m_len - 1 - (k % m_len)]);
      end
      send_frame(30, f[0], c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable serial-pattern detection controller. It configures, sequences and reports on a single shared bit-pattern matcher, generalising the fixed 1011 detector to runtime-selected patterns of up to PAT_W bits with selectable overlap. Serial bits arrive over a valid/ready handshake, framed by a last flag. Each frame's match count is returned through a done/ack handshake. It sits between a bit-stream source and a status/host interface.

## Interface
- PAT_W, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- DEF_PATTERN, 8'b0000_1011: pattern loaded at reset (LSB-aligned).
- DEF_LEN, 4: pattern length loaded at reset.
- LEN_W, $clog2(PAT_W+1): derived width of the length field; not overridden.

- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cfg_we  in  1  config write strobe; honoured only in IDLE.
- cfg_pattern  in  PAT_W  pattern, LSB-aligned; bit [len-1] is the first bit received.
- cfg_len  in  LEN_W  pattern length; legal range 1..PAT_W.
- cfg_overlap  in  1  1 = overlapping matches, 0 = restart after a match.
- cfg_err  out  1  one-cycle pulse on a rejected write.
- start  in  1  begin a frame; honoured only in IDLE.
- busy  out  1  high in RUN and DONE.
- bit_valid  in  1  source has a bit.
- bit_in  in  1  serial data bit.
- bit_last  in  1  qualifies the final bit of the frame.
- bit_ready  out  1  high exactly in RUN.
- match  out  1  one-cycle pulse per detected match.
- match_count  out  CNT_W  matches in the current or last frame; saturating.
- done  out  1  frame complete, result valid.
- done_ack  in  1  consumer takes the result.

## Operation
- **Reset.** Every output resets to 0.
  - State resets to IDLE.
  - Config resets to DEF_PATTERN, DEF_LEN and overlap=1.
  - History and fill counter clear.
- **IDLE.**
  - cfg_we with cfg_len in 1..PAT_W loads all three config fields.
  - cfg_we with cfg_len = 0 or > PAT_W loads nothing and pulses cfg_err.
  - On start: go to RUN, clear history, fill and match_count.
  - cfg_we and start in the same cycle: the write is applied and the frame uses the new config. If the write is illegal, the frame uses the old config.
- **RUN.** An accepted bit is bit_valid & bit_ready. For each accepted bit:
  - Shift it into the PAT_W-bit history at the LSB.
  - Set fill = min(fill+1, PAT_W).
  - A hit occurs when fill ≥ cfg_len and history[cfg_len-1:0] == cfg_pattern[cfg_len-1:0].
  - On a hit: pulse match, increment match_count (saturates at 2^CNT_W−1), and clear fill if cfg_overlap = 0.
  - If the accepted bit carries bit_last, go to DONE.
  - Cycles with bit_valid low change nothing.
- **DONE.**
  - done and match_count are held.
  - bit_ready is 0, so bits offered are ignored.
  - done_ack while done = 1 returns to IDLE; match_count stays visible until the next start.
- **Ignored inputs.** start in RUN/DONE, cfg_we in RUN/DONE, and done_ack outside DONE are all ignored.
- **Reset mid-frame.** Reset aborts to IDLE with all state, count and config restored to their reset values; no done is produced.

## Timing
- Match latency: a bit accepted at edge N gives match high during cycle N+1 only, and match_count updated at the same edge.
- Last bit: when the last bit completes a pattern, match and done rise together and the count includes that match.
- State transitions:
  - start at edge N: bit_ready high from cycle N+1.
  - Last bit accepted at edge N: bit_ready low and done high from cycle N+1.
  - done_ack at edge N: done low from cycle N+1.
- Throughput: one bit per cycle with no bubbles.
- cfg_err asserts the cycle after the offending cfg_we.

## Structure
- Package seq_det_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - localparams DEF_PATTERN and DEF_LEN;
  - the LEN_W helper.
- Sub-module seq_det_core contains the history shift register, fill counter and masked comparator.
  - Inputs: shift enable, bit, clear, cfg.
  - Output: hit (combinational).
- seq_det_ctrl itself holds the FSM, config registers, counter and handshakes.

## Test plan
- **Defaults.** After reset, send the frame 1,0,1,1,0,1,1 (last on the 7th bit). Expect match pulses after bits 4 and 7, done with match_count = 2, and match plus done coincident.
- **Non-overlap.** cfg overlap=0, pattern 1011, len 4; send the same frame. Expect one match after bit 4 and match_count = 1.
- **Short pattern.** cfg pattern 11, len 2; send 1,1,1,1. Overlap=1 gives count 3; overlap=0 gives count 2.
- **Handshake.** Random bit_valid gaps, plus bits offered in IDLE and DONE. Expect the same counts as the gap-free runs, bit_ready = 0 outside RUN, and no state change from ignored bits. Holding done_ack off for 10 cycles keeps done and the count stable.
- **Errors and saturation.**
  - cfg_len = 0 gives a cfg_err pulse with config unchanged.
  - cfg_we in RUN is ignored.
  - With CNT_W = 2, five matches give match_count = 3.
- **Reset mid-RUN.** Reset after 3 bits of a custom config. Expect IDLE, all outputs 0, and config back to 1011/4/overlap. A new frame then detects 1011.
